// File: rtl/prod_to_bcd_pkg.sv
// Shared constants and FSM state type for the product-to-BCD converter.
// Used by prod_to_bcd and bcd_add3_cell.
package prod_to_bcd_pkg;

  localparam int unsigned     DIGIT_W = 4;
  localparam logic [3:0]      ADD3_TH = 4'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/prod_to_bcd_add3_cell.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next digit.
module bcd_add3_cell
  import prod_to_bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q
);

  // d <= 9 in a valid BCD digit, so d+3 stays within 4 bits.
  assign q = (d >= ADD3_TH) ? d + 4'd3 : d;

endmodule

// File: rtl/prod_to_bcd.sv
// Sequential binary-to-BCD converter (shift-add-3, one input bit per clock)
// with valid/ready on both sides. Define PROD_TO_BCD_LZ_BLANK_EN to add out_lz.
module prod_to_bcd
  import prod_to_bcd_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_W-1:0]         in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DIGIT_W*DIGITS-1:0] out_bcd,
  output logic                    busy
`ifdef PROD_TO_BCD_LZ_BLANK_EN
  ,
  output logic [DIGITS-1:0]       out_lz
`endif
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);

  state_e             state;
  logic [CNT_W-1:0]   count;
  logic [IN_W-1:0]    bin_reg;
  logic [BCD_W-1:0]   bcd_reg;
  logic [BCD_W-1:0]   corr;
  logic [BCD_W-1:0]   bcd_next;
  logic [IN_W-1:0]    bin_next;
  logic               unused_carry;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_cell u_cell (
      .d (corr_src(g)),
      .q (corr[g*DIGIT_W +: DIGIT_W])
    );
  end

  function automatic logic [DIGIT_W-1:0] corr_src(input int idx);
    return bcd_reg[idx*DIGIT_W +: DIGIT_W];
  endfunction

  // The corrected top digit's MSB is always 0 when 10^DIGITS > 2^IN_W - 1.
  assign {unused_carry, bcd_next, bin_next} = {corr, bin_reg, 1'b0};

  assign in_ready  = (state == IDLE);
  assign busy      = (state == SHIFT);
  assign out_valid = (state == DONE);

`ifdef PROD_TO_BCD_LZ_BLANK_EN
  logic [DIGITS-1:0] lz_next;
  logic              seen_nz;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    lz_next = '0;
    seen_nz = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (bcd_next[i*DIGIT_W +: DIGIT_W] != '0) seen_nz = 1'b1;
      lz_next[i] = !seen_nz;
    end
  end
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      bin_reg <= '0;
      bcd_reg <= '0;
      out_bcd <= '0;
`ifdef PROD_TO_BCD_LZ_BLANK_EN
      out_lz  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin_reg <= in_data;
            bcd_reg <= '0;
            count   <= CNT_W'(IN_W);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          bin_reg <= bin_next;
          bcd_reg <= bcd_next;
          count   <= count - 1'b1;
          // Last iteration: publish the finished value so out_bcd never shows a partial.
          if (count == CNT_W'(1)) begin
            out_bcd <= bcd_next;
`ifdef PROD_TO_BCD_LZ_BLANK_EN
            out_lz  <= lz_next;
`endif
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
